// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
package mul_share_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_REQ    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/mul_share_arb_if.sv
// Request/response bus between datapath clients and the shared multiplier.
interface mul_share_arb_if
    import mul_share_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ID_W      = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*DataWidth-1:0] req_a;
    logic [NUM_REQ*DataWidth-1:0] req_b;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_W-1:0]              rsp_id;
    logic [2*DataWidth:0]         rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mul_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter; MUL_SHARE_FIXED_PRIO_EN selects
// lowest-index-wins fixed priority instead (rrPtr then ignored).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rrPtr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grantIdx,
    output logic               anyGrant
);
    logic found;
`ifndef MUL_SHARE_FIXED_PRIO_EN
    int idx;
`endif

    always_comb begin
        found    = 1'b0;
        grantIdx = '0;
`ifdef MUL_SHARE_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found    = 1'b1;
                grantIdx = ID_W'(i);
            end
        end
`else
        idx = 0;
        // Search upward from the pointer, wrapping past NUM_REQ-1.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rrPtr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grantIdx = ID_W'(idx);
            end
        end
`endif
    end

`ifdef MUL_SHARE_FIXED_PRIO_EN
    logic unusedPtr;
    assign unusedPtr = ^rrPtr;
`endif

    assign anyGrant = found & enable;
    assign grant    = anyGrant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grantIdx) : '0;
endmodule

// File: rtl/mul_share_arb.sv
// One unsigned multiplier shared by NUM_REQ clients: grant, latch, multiply, respond.
// Define MUL_SHARE_FIXED_PRIO_EN for fixed-priority arbitration (no rr pointer).
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter  int DataWidth = DEF_DATA_WIDTH,
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input logic            clk,
    input logic            rst_n,
    mul_share_arb_if.slave bus
);
    state_t                 state, stateNxt;
    logic [ID_W-1:0]        rrPtr;
    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        grantIdx;
    logic                   anyGrant;
    logic [DataWidth-1:0]   aQ, bQ;
    logic [ID_W-1:0]        idQ;
    logic                   rspValid;
    logic [ID_W-1:0]        rspId;
    logic [2*DataWidth:0]   rspData;
    logic [2*DataWidth-1:0] prod;

    // Gating with rst_n keeps req_ready low while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) uArb (
        .req      (bus.req_valid),
        .rrPtr    (rrPtr),
        .enable   ((state == ST_IDLE) && rst_n),
        .grant    (grant),
        .grantIdx (grantIdx),
        .anyGrant (anyGrant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE: if (anyGrant) stateNxt = ST_MUL;
            ST_MUL:  stateNxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) stateNxt = ST_IDLE;
            default: stateNxt = ST_IDLE;
        endcase
    end

`ifdef MUL_SHARE_FIXED_PRIO_EN
    assign rrPtr = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr <= '0;
        end else if (anyGrant) begin
            rrPtr <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
        end
    end
`endif

    assign prod = (2*DataWidth)'(aQ) * (2*DataWidth)'(bQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aQ       <= '0;
            bQ       <= '0;
            idQ      <= '0;
            rspValid <= 1'b0;
            rspId    <= '0;
            rspData  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (anyGrant) begin
                    aQ  <= bus.req_a[int'(grantIdx)*DataWidth +: DataWidth];
                    bQ  <= bus.req_b[int'(grantIdx)*DataWidth +: DataWidth];
                    idQ <= grantIdx;
                end
                ST_MUL: begin
                    rspData  <= {1'b0, prod};
                    rspId    <= idQ;
                    rspValid <= 1'b1;
                end
                ST_RESP: if (bus.rsp_ready) rspValid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rspValid;
    assign bus.rsp_id    = rspId;
    assign bus.rsp_data  = rspData;
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: scoreboard queue filled by stimulus, drained by a monitor.
module tb_mul_share_arb;
    logic clk;
    logic rst_n;
    int   nChecks = 0;
    int   nFails  = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [32:0] data;
    } exp_t;
    exp_t sbQ[$];
    exp_t monE;

    mul_share_arb_if ifc ();

    mul_share_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: every accepted response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ifc.rsp_valid && ifc.rsp_ready) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_rsp: got id %0d data %0h, required no response (t=%0t)",
                         ifc.rsp_id, ifc.rsp_data, $time);
            end else begin
                monE = sbQ.pop_front();
                chk("rsp_id", 64'(ifc.rsp_id), 64'(monE.id));
                chk("rsp_data", 64'(ifc.rsp_data), 64'(monE.data));
            end
        end
    end

    task automatic setReq(input int id, input logic [15:0] a, input logic [15:0] b);
        ifc.req_valid[id]       = 1'b1;
        ifc.req_a[id*16 +: 16]  = a;
        ifc.req_b[id*16 +: 16]  = b;
    endtask

    // Issue one request and wait (bounded) for its grant; returns just after the handshake edge.
    task automatic serve(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [32:0] expData, input bit doPush);
        bit got;
        @(posedge clk); #1;
        setReq(id, a, b);
        if (doPush) sbQ.push_back('{id: 2'(id), data: expData});
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (ifc.req_ready[id]) begin
                got = 1'b1;
                chk("grant_onehot", 64'(ifc.req_ready), 64'(4'b1 << id));
            end
            @(posedge clk); #1;
        end
        chk("grant_seen", 64'(got), 64'(1));
        ifc.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && sbQ.size() != 0; c++) @(negedge clk);
        chk("drain_empty", 64'(sbQ.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    // Hold a set of requesters valid and check the grant sequence.
    task automatic grantSeq(input int n, input int order[8]);
        int grants;
        grants = 0;
        for (int c = 0; c < 60 && grants < n; c++) begin
            @(negedge clk);
            chk("grant_onehot0", 64'($onehot0(ifc.req_ready)), 64'(1));
            if (ifc.req_ready != 0) begin
                chk("grant_order", 64'(ifc.req_ready), 64'(4'b1 << order[grants]));
                grants++;
                if (grants == n) begin
                    @(posedge clk); #1;
                    ifc.req_valid = '0;
                end
            end
        end
        chk("grant_count", 64'(grants), 64'(n));
    endtask

    initial begin
        int order[8];
        rst_n         = 1'b0;
        ifc.req_valid = '1;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.rsp_ready = 1'b0;
        #12;
        chk("reset_rsp_valid", 64'(ifc.rsp_valid), 64'(0));
        chk("reset_rsp_id",    64'(ifc.rsp_id),    64'(0));
        chk("reset_rsp_data",  64'(ifc.rsp_data),  64'(0));
        chk("reset_req_ready", 64'(ifc.req_ready), 64'(0));
        ifc.req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: all valid, a=i+1, b=3
        ifc.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) setReq(i, 16'(i + 1), 16'd3);
`ifdef MUL_SHARE_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) sbQ.push_back('{id: 2'd0, data: 33'd3});
`else
        order = '{0, 1, 2, 3, 0, 0, 0, 0};
        sbQ.push_back('{id: 2'd0, data: 33'd3});
        sbQ.push_back('{id: 2'd1, data: 33'd6});
        sbQ.push_back('{id: 2'd2, data: 33'd9});
        sbQ.push_back('{id: 2'd3, data: 33'd12});
        sbQ.push_back('{id: 2'd0, data: 33'd3});
`endif
        grantSeq(5, order);
        drain();

        // Single request with latency check
        serve(0, 16'd2, 16'd5, 33'd10, 1'b1);
        @(negedge clk);
        chk("lat_mul_rsp_valid", 64'(ifc.rsp_valid), 64'(0));
        chk("lat_mul_req_ready", 64'(ifc.req_ready), 64'(0));
        @(negedge clk);
        chk("lat_rsp_valid", 64'(ifc.rsp_valid), 64'(1));
        drain();

        // Backpressure with a second requester waiting
        ifc.rsp_ready = 1'b0;
        serve(2, 16'd7, 16'd9, 33'd63, 1'b1);
        setReq(1, 16'd4, 16'd4);
        sbQ.push_back('{id: 2'd1, data: 33'd16});
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            chk("bp_rsp_valid", 64'(ifc.rsp_valid), 64'(1));
            chk("bp_rsp_data",  64'(ifc.rsp_data),  64'(63));
            chk("bp_rsp_id",    64'(ifc.rsp_id),    64'(2));
            chk("bp_req_ready", 64'(ifc.req_ready), 64'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        ifc.rsp_ready = 1'b1;
        @(posedge clk); #1;
        ifc.rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", 64'(ifc.rsp_valid), 64'(0));
        chk("bp_next_grant",    64'(ifc.req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        ifc.req_valid = '0;
        ifc.rsp_ready = 1'b1;
        drain();

        // Extremes
        serve(1, 16'h0000, 16'h1234, 33'h0, 1'b1);
        drain();
        serve(3, 16'hFFFF, 16'hFFFF, 33'h0_FFFE_0001, 1'b1);
        drain();

        // Reset while in MUL: result discarded, outputs cleared at once
        serve(2, 16'd3, 16'd3, 33'd9, 1'b0);
        #1;
        ifc.req_valid[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 64'(ifc.rsp_valid), 64'(0));
        chk("rst_mid_rsp_id",    64'(ifc.rsp_id),    64'(0));
        chk("rst_mid_rsp_data",  64'(ifc.rsp_data),  64'(0));
        chk("rst_mid_req_ready", 64'(ifc.req_ready), 64'(0));
        ifc.req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 64'(ifc.rsp_valid), 64'(0));
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) setReq(i, 16'(i + 1), 16'd3);
        sbQ.push_back('{id: 2'd0, data: 33'd3});
        @(negedge clk);
        chk("post_rst_first_grant", 64'(ifc.req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        ifc.req_valid = '0;
        drain();

        // Requesters 1 and 3 held valid
        setReq(1, 16'd1, 16'd5);
        setReq(3, 16'd2, 16'd5);
`ifdef MUL_SHARE_FIXED_PRIO_EN
        order = '{1, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) sbQ.push_back('{id: 2'd1, data: 33'd5});
`else
        order = '{1, 3, 1, 3, 0, 0, 0, 0};
        sbQ.push_back('{id: 2'd1, data: 33'd5});
        sbQ.push_back('{id: 2'd3, data: 33'd10});
        sbQ.push_back('{id: 2'd1, data: 33'd5});
        sbQ.push_back('{id: 2'd3, data: 33'd10});
`endif
        grantSeq(4, order);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
